// File: rtl/colorclk_nco.sv
// Multi-standard phase-accumulator colour-subcarrier clock generator (4x fsc output).
// Optional quadrant/fsc outputs are built only when COLORCLK_QUAD_EN is defined.
module colorclk_nco #(
  parameter int               ACC_W    = 32,
  parameter logic [ACC_W-1:0] INC_PAL  = ACC_W'(761689904),
  parameter logic [ACC_W-1:0] INC_NTSC = ACC_W'(614961152),
  parameter logic [ACC_W-1:0] INC_PALM = ACC_W'(614285376),
  parameter logic [ACC_W-1:0] INC_PALN = ACC_W'(615392578)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             phase_rst,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_sel,
  input  logic [ACC_W-1:0] cfg_inc,
  output logic             clkcolor4x,
  output logic             color_ce,
  output logic             clkcolor,
  output logic [1:0]       quad
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] inc_act;
  logic [ACC_W-1:0] inc_tbl [4];
  logic [ACC_W:0]   sum;
  logic             carry;
  logic             reload;
  logic             rise;

  always_comb begin
    sum    = {1'b0, acc} + {1'b0, inc_act};
    carry  = sum[ACC_W];
    reload = !en || phase_rst || carry;
    rise   = sum[ACC_W-1] && !acc[ACC_W-1];
  end

  // NOTE: the increment table is reset like any register: its power-up contents are the four
  // standard increments, so it must be flops with reset values, not an uninitialised RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inc_tbl[0] <= INC_PAL;
      inc_tbl[1] <= INC_NTSC;
      inc_tbl[2] <= INC_PALM;
      inc_tbl[3] <= INC_PALN;
    end else if (cfg_we) begin
      inc_tbl[cfg_sel] <= cfg_inc;
    end
  end

  // NOTE: non-blocking assignments here mean a reload in the same cycle as a table write
  // picks up the entry's old value; the new one is visible from the next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc        <= '0;
      inc_act    <= INC_PAL;
      clkcolor4x <= 1'b1;
      color_ce   <= 1'b0;
    end else begin
      // Increment only changes at period boundaries, so retuning never produces runt pulses.
      if (reload) inc_act <= inc_tbl[mode];
      if (!en) begin
        acc        <= '0;
        clkcolor4x <= 1'b1;
        color_ce   <= 1'b0;
      end else if (phase_rst) begin
        acc        <= '0;
        clkcolor4x <= 1'b0;
        color_ce   <= 1'b0;
      end else begin
        acc        <= sum[ACC_W-1:0];
        clkcolor4x <= sum[ACC_W-1];
        color_ce   <= rise;
      end
    end
  end

`ifdef COLORCLK_QUAD_EN
  logic [1:0] quad_q;
  logic [1:0] quad_nxt;
  logic       clkcolor_q;

  always_comb begin
    quad_nxt = quad_q;
    if (!en || phase_rst) quad_nxt = 2'd0;
    else if (rise)        quad_nxt = quad_q + 2'd1;
  end

  // fsc is derived from the quadrant so it stays phase-locked to the 4x clock edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quad_q     <= 2'd0;
      clkcolor_q <= 1'b1;
    end else begin
      quad_q     <= quad_nxt;
      clkcolor_q <= ~quad_nxt[1];
    end
  end

  assign quad     = quad_q;
  assign clkcolor = clkcolor_q;
`else
  assign quad     = 2'd0;
  assign clkcolor = 1'b0;
`endif

endmodule

// File: tb/tb_colorclk_nco.sv
// Directed self-checking bench for colorclk_nco: reset, latency, retune, table writes,
// phase reset, enable gating and quadrant outputs (expectations follow COLORCLK_QUAD_EN).
module tb_colorclk_nco;

  localparam int ACC_W = 32;
`ifdef COLORCLK_QUAD_EN
  localparam bit QUAD = 1'b1;
`else
  localparam bit QUAD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b1;
  logic [1:0]       mode = 2'd0;
  logic             phase_rst = 1'b0;
  logic             cfg_we = 1'b0;
  logic [1:0]       cfg_sel = 2'd0;
  logic [ACC_W-1:0] cfg_inc = '0;
  logic             clkcolor4x;
  logic             color_ce;
  logic             clkcolor;
  logic [1:0]       quad;

  int checks = 0;
  int failures = 0;

  colorclk_nco #(.ACC_W(ACC_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .mode       (mode),
    .phase_rst  (phase_rst),
    .cfg_we     (cfg_we),
    .cfg_sel    (cfg_sel),
    .cfg_inc    (cfg_inc),
    .clkcolor4x (clkcolor4x),
    .color_ce   (color_ce),
    .clkcolor   (clkcolor),
    .quad       (quad)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Quadrant expectations collapse to constants when the feature is compiled out.
  function automatic logic [1:0] exp_quad(input logic [1:0] q);
    return QUAD ? q : 2'd0;
  endfunction

  function automatic logic exp_clkcolor(input logic [1:0] q);
    return QUAD ? ~q[1] : 1'b0;
  endfunction

  int cnt;
  logic [31:0] ok;
  logic        mode_pat [2:7];

  initial begin
    mode_pat[2] = 1'b1; mode_pat[3] = 1'b1; mode_pat[4] = 1'b0;
    mode_pat[5] = 1'b0; mode_pat[6] = 1'b0; mode_pat[7] = 1'b1;

    // Reset state
    step(); step();
    check("rst_cx4", 32'(clkcolor4x), 1);
    check("rst_ce", 32'(color_ce), 0);
    check("rst_quad", 32'(quad), 0);
    check("rst_clkcolor", 32'(clkcolor), 32'(exp_clkcolor(2'd0)));

    // PAL from reset: first rise after ceil(2^31/761689904) = 3 cycles
    rst = 1'b0;
    step(); check("pal_k1_cx4", 32'(clkcolor4x), 0);
    step(); check("pal_k2_cx4", 32'(clkcolor4x), 0);
            check("pal_k2_ce", 32'(color_ce), 0);
    step(); check("pal_k3_cx4", 32'(clkcolor4x), 1);
            check("pal_k3_ce", 32'(color_ce), 1);
            check("pal_k3_quad", 32'(quad), 32'(exp_quad(2'd1)));
    step(); check("pal_k4_ce", 32'(color_ce), 0);

    // PAL rate: 10000 * 761689904 / 2^32 = 1773.4 pulses
    cnt = 0;
    repeat (10000) begin step(); if (color_ce) cnt++; end
    ok = (cnt >= 1773 && cnt <= 1774) ? 32'd1 : 32'd0;
    if (!ok) $display("pal count observed %0d", cnt);
    check("pal_rate_in_1773_1774", ok, 1);

    // Same-cycle write + reload of entry 2 uses the old PAL-M increment: rise at k=4
    cfg_we = 1'b1; cfg_sel = 2'd2; cfg_inc = 32'h4000_0000; mode = 2'd2; phase_rst = 1'b1;
    step();
    cfg_we = 1'b0; phase_rst = 1'b0;
    check("prst_cx4", 32'(clkcolor4x), 0);
    check("prst_ce", 32'(color_ce), 0);
    check("prst_quad", 32'(quad), 0);
    step(); step(); step();
    check("palm_old_k3_cx4", 32'(clkcolor4x), 0);
    step();
    check("palm_old_k4_cx4", 32'(clkcolor4x), 1);
    check("palm_old_k4_ce", 32'(color_ce), 1);

    // New entry 2^30: period 4 clk, duty 2/2, quad steps every 4 clk
    phase_rst = 1'b1;
    step();
    phase_rst = 1'b0;
    check("q_prst_cx4", 32'(clkcolor4x), 0);
    for (int k = 1; k <= 16; k++) begin
      step();
      check($sformatf("q_k%0d_cx4", k), 32'(clkcolor4x), (k % 4 == 2 || k % 4 == 3) ? 1 : 0);
      if (k % 4 == 2) begin
        check($sformatf("q_k%0d_quad", k), 32'(quad), 32'(exp_quad(2'((k + 2) / 4))));
        check($sformatf("q_k%0d_clkcolor", k), 32'(clkcolor), 32'(exp_clkcolor(2'((k + 2) / 4))));
      end
    end

    // Mode change mid-period takes effect only after the next carry
    phase_rst = 1'b1;
    step();
    phase_rst = 1'b0;
    step();
    mode = 2'd0;
    for (int k = 2; k <= 7; k++) begin
      step();
      check($sformatf("retune_k%0d_cx4", k), 32'(clkcolor4x), 32'(mode_pat[k]));
    end

    // NTSC rate: 10000 * 614961152 / 2^32 = 1431.8 pulses
    mode = 2'd1; phase_rst = 1'b1;
    step();
    phase_rst = 1'b0;
    cnt = 0;
    repeat (10000) begin step(); if (color_ce) cnt++; end
    ok = (cnt >= 1431 && cnt <= 1432) ? 32'd1 : 32'd0;
    if (!ok) $display("ntsc count observed %0d", cnt);
    check("ntsc_rate_in_1431_1432", ok, 1);

    // Zero increment freezes the output
    cfg_we = 1'b1; cfg_sel = 2'd3; cfg_inc = '0;
    step();
    cfg_we = 1'b0; mode = 2'd3; phase_rst = 1'b1;
    step();
    phase_rst = 1'b0;
    cnt = 0;
    repeat (20) begin step(); if (color_ce || clkcolor4x) cnt++; end
    check("freeze_activity", 32'(cnt), 0);

    // en=0 wins over phase_rst; output idles high for 10 clk, then restarts deterministically
    en = 1'b0; phase_rst = 1'b1; mode = 2'd0;
    step();
    phase_rst = 1'b0;
    check("dis_prio_cx4", 32'(clkcolor4x), 1);
    cnt = 0;
    repeat (9) begin step(); if (color_ce || !clkcolor4x || quad != 2'd0) cnt++; end
    check("dis_idle_violations", 32'(cnt), 0);
    en = 1'b1;
    step(); check("en_k1_cx4", 32'(clkcolor4x), 0);
    step(); check("en_k2_cx4", 32'(clkcolor4x), 0);
    step(); check("en_k3_cx4", 32'(clkcolor4x), 1);
            check("en_k3_ce", 32'(color_ce), 1);
            check("en_k3_quad", 32'(quad), 32'(exp_quad(2'd1)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
